// File: rtl/vproc_vreg_pend_tracker.sv
`default_nettype none
// ============================================================================
// Module   : vproc_vreg_pend_tracker
// Brief    : Per-vreg outstanding-write counters with RAW/capacity dispatch
//            gating. Optional macro VPROC_PEND_CLR_BYPASS_EN lets a final
//            clear release a dependent dispatch in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vproc_vreg_pend_tracker #(
    parameter int unsigned CNT_W          = 2,
    parameter logic        DONT_CARE_ZERO = 1'b0
) (
    input  logic        clk_i,
    input  logic        async_rst_ni,
    input  logic        dispatch_valid_i,
    output logic        dispatch_ready_o,
    input  logic [31:0] dispatch_rd_mask_i,
    input  logic [31:0] dispatch_rs_mask_i,
    input  logic [31:0] pend_vreg_wr_clr_i,
    input  logic        flush_i,
    output logic [31:0] pend_vreg_wr_o,
    output logic        busy_o,
    output logic        err_underflow_o
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [31:0] w_pend;
    logic [31:0] w_sat;
    logic [31:0] w_last;
    logic [31:0] w_hz;
    logic [31:0] w_inc;
    logic [31:0] w_underflow;
    logic        w_acc;
    logic        r_err;
    logic        w_unused_dcz;

    assign w_unused_dcz = DONT_CARE_ZERO;

    assign w_acc       = dispatch_valid_i & dispatch_ready_o;
    assign w_inc       = {32{w_acc}} & dispatch_rd_mask_i;
    // A simultaneous increment cancels the clear, so it cannot underflow.
    assign w_underflow = pend_vreg_wr_clr_i & ~w_inc & ~w_pend;

    generate
        for (genvar j = 0; j < 32; j++) begin : g_vreg
            logic [CNT_W-1:0] r_cnt;

            assign w_pend[j] = |r_cnt;
            assign w_sat[j]  = &r_cnt;
            assign w_last[j] = (r_cnt == c_CNT_ONE);

            always_ff @(posedge clk_i or negedge async_rst_ni) begin
                if (!async_rst_ni) begin
                    r_cnt <= '0;
                end else if (flush_i) begin
                    r_cnt <= '0;
                end else if (w_inc[j] && !pend_vreg_wr_clr_i[j]) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end else if (!w_inc[j] && pend_vreg_wr_clr_i[j] && w_pend[j]) begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
            end
        end
    endgenerate

`ifdef VPROC_PEND_CLR_BYPASS_EN
    assign w_hz = w_pend & ~(pend_vreg_wr_clr_i & w_last);
`else
    assign w_hz = w_pend;
    logic w_unused_last;
    assign w_unused_last = |w_last;
`endif

    assign dispatch_ready_o = ~flush_i
                            & ~|(dispatch_rs_mask_i & w_hz)
                            & ~|(dispatch_rd_mask_i & w_sat);

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_err <= 1'b0;
        end else if (flush_i) begin
            r_err <= 1'b0;
        end else if (|w_underflow) begin
            r_err <= 1'b1;
        end
    end

    assign pend_vreg_wr_o  = w_pend;
    assign busy_o          = |w_pend;
    assign err_underflow_o = r_err;

endmodule
`default_nettype wire
